paddle_input_conditioner: RTL

Multi-channel paddle position conditioner between `hps_io` and the game core. Each channel selects its source (analog Y, analog X, inverted X, spinner/paddle byte, or digital up/down buttons), widens it to the core's position width, applies a tick-rate smoothing filter, and presents a frame-stable position latched on VBlank rise. Generalises the per-player paddle mapping in the `emu` top to N channels with digital-button control, smoothing and frame-synchronous output.

---
 rtl/paddle_input_conditioner.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/paddle_input_conditioner.sv
// Purpose : per-channel paddle source select, MSB-replicated widening, tick-rate
//           smoothing filter and frame-stable position latched on VBlank rise.
// Latency : target -> acc on the tick edge; acc -> vpos one edge after vblank rises.
// Backpressure: none; free-running, vpos_upd is a one-cycle strobe with no handshake.
//
// Ports:
//   clk_sys            system clock (only clock)
//   reset              synchronous, active-high
//   mode     [3*CH]    per-channel source: 0 Y, 1 X, 2 Inv-X, 3 Paddle, 4 Digital (5..7 = Y)
//   analog   [16*CH]   per-channel signed stick, [15:8] Y, [7:0] X
//   paddle   [8*CH]    per-channel unsigned paddle byte
//   btn_up/btn_down    per-channel digital-mode buttons, active-high
//   vblank             core vertical blank
//   vpos     [POS_W*CH] registered conditioned positions
//   vpos_upd           strobe coincident with each vpos update

module paddle_input_conditioner #(
    parameter int CHANNELS     = 2,
    parameter int POS_W        = 8,
    parameter int TICK_DIV     = 7159,
    parameter int FILTER_SHIFT = 2,
    parameter int STEP         = 2,
    parameter int ACCEL_TICKS  = 32
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [3*CHANNELS-1:0]     mode,
    input  logic [16*CHANNELS-1:0]    analog,
    input  logic [8*CHANNELS-1:0]     paddle,
    input  logic [CHANNELS-1:0]       btn_up,
    input  logic [CHANNELS-1:0]       btn_down,
    input  logic                      vblank,
    output logic [POS_W*CHANNELS-1:0] vpos,
    output logic                      vpos_upd
);

    localparam logic [2:0] MODE_Y    = 3'd0;
    localparam logic [2:0] MODE_X    = 3'd1;
    localparam logic [2:0] MODE_INVX = 3'd2;
    localparam logic [2:0] MODE_PAD  = 3'd3;
    localparam logic [2:0] MODE_DIG  = 3'd4;

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACCEL_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);

    // 0x80 widened the same way as every raw value: top POS_W bits of {raw, raw}.
    localparam logic [POS_W-1:0]  CENTER    = POS_W'(16'h8080 >> (16 - POS_W));

    localparam logic [8:0]        STEP_BASE = 9'(STEP);
    localparam logic [8:0]        STEP_FAST = 9'(2 * STEP);

    // ------------------------------------------------------------------
    // Shared update tick and VBlank edge detect
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             vblank_d;
    logic             vb_rise;

    assign tick    = (tick_cnt == TICK_LAST);
    assign vb_rise = vblank & ~vblank_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tick_cnt <= '0;
            vblank_d <= 1'b0;
            vpos_upd <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_ONE;
            vblank_d <= vblank;
            vpos_upd <= vb_rise;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [2:0]              ch_mode;
        logic [7:0]              ax;
        logic [7:0]              ay;
        logic [7:0]              raw;
        logic [POS_W-1:0]        target;

        logic [POS_W-1:0]        acc;
        logic [POS_W-1:0]        vpos_r;
        logic [7:0]              dpos;
        logic [HOLD_W-1:0]       hold;
        logic                    last_dir;
        logic [2:0]              mode_prev;

        logic signed [POS_W:0]   diff;
        logic signed [POS_W:0]   shft;
        logic [POS_W-1:0]        stp;
        logic [POS_W-1:0]        acc_filt;

        logic                    up_only;
        logic                    dn_only;
        logic                    one_btn;
        logic                    reversal;
        logic [8:0]              step9;
        logic [8:0]              up_sum;
        logic [8:0]              dn_dif;
        logic [7:0]              dpos_step;
        logic [HOLD_W-1:0]       hold_step;
        logic                    mode_chg;

        assign ch_mode = mode[3*c +: 3];
        assign ay      = analog[16*c+8 +: 8];
        assign ax      = analog[16*c +: 8];

        // Signed stick to offset binary is an MSB flip (+0x80 wraps by design);
        // Inv-X mirrors around the centre so -128 maps to 0xFF and +127 to 0x00.
        always_comb begin
            case (ch_mode)
                MODE_Y:    raw = ay + 8'h80;
                MODE_X:    raw = ax + 8'h80;
                MODE_INVX: raw = ax ^ 8'h7F;
                MODE_PAD:  raw = paddle[8*c +: 8];
                MODE_DIG:  raw = dpos;
                default:   raw = ay + 8'h80;
            endcase
        end

        // MSB replication: 0x00 -> all zeros, 0xFF -> all ones.
        assign target = POS_W'({raw, raw} >> (16 - POS_W));

        // Smoothing: move acc by (target-acc)>>>shift, but never by zero while a
        // difference remains, so acc lands exactly on target.
        assign diff = $signed({1'b0, target}) - $signed({1'b0, acc});
        assign shft = diff >>> FILTER_SHIFT;

        always_comb begin
            stp = shft[POS_W-1:0];
            if (diff != '0 && shft == '0) begin
                stp = diff[POS_W] ? '1 : POS_ONE;
            end
        end

        // acc+s always lies between acc and target, so the modular add is exact.
        assign acc_filt = acc + stp;

        // Digital buttons
        assign up_only  = btn_up[c] & ~btn_down[c];
        assign dn_only  = btn_down[c] & ~btn_up[c];
        assign one_btn  = up_only | dn_only;
        // A reversal restarts acceleration: this tick moves at base step.
        assign reversal = one_btn && (hold != '0) && (last_dir != up_only);
        assign step9    = (!reversal && hold == HOLD_MAX) ? STEP_FAST : STEP_BASE;

        // 9-bit sums: bit 8 flags overflow (up) or borrow (down), then saturate.
        assign up_sum = {1'b0, dpos} + step9;
        assign dn_dif = {1'b0, dpos} - step9;

        always_comb begin
            dpos_step = dpos;
            if (up_only) begin
                dpos_step = up_sum[8] ? 8'hFF : up_sum[7:0];
            end else if (dn_only) begin
                dpos_step = dn_dif[8] ? 8'h00 : dn_dif[7:0];
            end
        end

        always_comb begin
            hold_step = '0;
            if (one_btn && !reversal) begin
                hold_step = (hold == HOLD_MAX) ? HOLD_MAX : hold + HOLD_ONE;
            end
        end

        assign mode_chg = (ch_mode != mode_prev);

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                acc       <= CENTER;
                vpos_r    <= CENTER;
                dpos      <= 8'h80;
                hold      <= '0;
                last_dir  <= 1'b0;
                // Track the live mode so leaving reset never looks like a change.
                mode_prev <= ch_mode;
            end else begin
                mode_prev <= ch_mode;
                if (mode_chg) begin
                    // Snap to the new source; entering digital restarts at centre.
                    if (ch_mode == MODE_DIG) begin
                        acc  <= CENTER;
                        dpos <= 8'h80;
                        hold <= '0;
                    end else begin
                        acc  <= target;
                    end
                end else if (tick) begin
                    acc <= acc_filt;
                    if (ch_mode == MODE_DIG) begin
                        dpos <= dpos_step;
                        hold <= hold_step;
                        if (one_btn) begin
                            last_dir <= up_only;
                        end
                    end
                end
                // Non-blocking read: a same-cycle tick leaves the pre-tick acc here.
                if (vb_rise) begin
                    vpos_r <= acc;
                end
            end
        end

        assign vpos[c*POS_W +: POS_W] = vpos_r;
    end

endmodule
